// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'hF;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // One-cold column drive for column index c.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Lowest-index row pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key handoff between the scanner (master) and the key consumer (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  key_code_t key_code_o;
  logic      key_valid_o;
  logic      key_ready_i;
  logic      key_held_o;

  modport master (
    output key_code_o,
    output key_valid_o,
    output key_held_o,
    input  key_ready_i
  );

  modport slave (
    input  key_code_o,
    input  key_valid_o,
    input  key_held_o,
    output key_ready_i
  );
endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for asynchronous keypad row inputs.
module keypad_row_sync #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-driving 4x4 keypad scanner with press/release debounce and valid/ready key output.
// Optional row synchronizer enabled by defining KEYPAD_ROW_SYNC_EN.
//
// state    | meaning
// SCAN     | drive column c, sample rows at end of each SCAN_DIV period
// DEBOUNCE | column held, rows must match captured pattern for DEB_CYCLES
// HOLD     | key accepted, waiting for all rows to go high
// RELEASE  | rows high, must stay high for DEB_CYCLES before moving on
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_COLS-1:0] col_o,
  keypad_scanner_if.master    key_if
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [NUM_ROWS-1:0] rows;

`ifdef KEYPAD_ROW_SYNC_EN
  keypad_row_sync #(
    .WIDTH     (NUM_ROWS),
    .RESET_VAL (ROWS_IDLE)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_i),
    .q     (rows)
  );
`else
  assign rows = row_i;
`endif

  scan_state_t         state;
  logic [1:0]          col;
  logic [DIV_W-1:0]    div;
  logic [DEB_W-1:0]    deb;
  logic [NUM_ROWS-1:0] pattern;
  key_code_t           key_code;
  logic                key_valid;
  logic                key_held;

  assign key_if.key_code_o  = key_code;
  assign key_if.key_valid_o = key_valid;
  assign key_if.key_held_o  = key_held;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= 2'd0;
      col_o     <= 4'b1110;
      div       <= '0;
      deb       <= '0;
      pattern   <= ROWS_IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      // A key accepted on the same edge overrides this clear below.
      if (key_valid && key_if.key_ready_i) key_valid <= 1'b0;

      case (state)
        SCAN: begin
          if (div == DIV_LAST) begin
            if (rows == ROWS_IDLE) begin
              col   <= col + 2'd1;
              col_o <= col_drive(col + 2'd1);
              div   <= '0;
            end else begin
              pattern <= rows;
              deb     <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rows != pattern) begin
            div   <= '0;
            state <= SCAN;
          end else if (deb == DEB_LAST) begin
            key_code  <= {lowest_low_row(pattern), col};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HOLD;
          end else begin
            deb <= deb + 1'b1;
          end
        end

        HOLD: begin
          if (rows == ROWS_IDLE) begin
            deb   <= '0;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          if (rows != ROWS_IDLE) begin
            state <= HOLD;
          end else if (deb == DEB_LAST) begin
            key_held <= 1'b0;
            col      <= col + 2'd1;
            col_o    <= col_drive(col + 2'd1);
            div      <= '0;
            state    <= SCAN;
          end else begin
            deb <= deb + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
